// File: rtl/neuron_batch_scorer.sv
// neuron_batch_scorer: scores a fixed-length batch of single-bit neuron
// predictions against their labels, counting samples, correct predictions
// and predicted ones, then pulses done for one cycle with the final totals.
// Optional feature macro: SCORER_CONFUSION_EN adds false-positive and
// false-negative counters; without it fp_cnt/fn_cnt are tied to zero.
module neuron_batch_scorer #(
  parameter int BATCH_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pred,
  input  logic             label,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] correct_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] fp_cnt,
  output logic [CNT_W-1:0] fn_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] correct_cnt_q, correct_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic             accept;
  logic             clear;

  assign accept = (state_q == RUN) && in_valid;
  assign clear  = (state_q == IDLE) && start;

  // State register; reset forces IDLE immediately, so no done pulse survives a reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (accept && (sample_cnt_q == LAST_IDX)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from the state register so no input reaches an output
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Core counters: cleared on start, bumped on each accepted sample, held otherwise
  always_comb begin
    sample_cnt_d  = sample_cnt_q;
    correct_cnt_d = correct_cnt_q;
    ones_cnt_d    = ones_cnt_q;
    if (clear) begin
      sample_cnt_d  = '0;
      correct_cnt_d = '0;
      ones_cnt_d    = '0;
    end else if (accept) begin
      sample_cnt_d = sample_cnt_q + ONE;
      if (pred ~^ label) correct_cnt_d = correct_cnt_q + ONE;
      if (pred)          ones_cnt_d    = ones_cnt_q + ONE;
    end
  end

  // Core counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q  <= '0;
      correct_cnt_q <= '0;
      ones_cnt_q    <= '0;
    end else begin
      sample_cnt_q  <= sample_cnt_d;
      correct_cnt_q <= correct_cnt_d;
      ones_cnt_q    <= ones_cnt_d;
    end
  end

  assign sample_cnt  = sample_cnt_q;
  assign correct_cnt = correct_cnt_q;
  assign ones_cnt    = ones_cnt_q;

`ifdef SCORER_CONFUSION_EN
  logic [CNT_W-1:0] fp_cnt_q, fp_cnt_d;
  logic [CNT_W-1:0] fn_cnt_q, fn_cnt_d;

  // Confusion counters: a wrong prediction is a false positive or a false negative
  always_comb begin
    fp_cnt_d = fp_cnt_q;
    fn_cnt_d = fn_cnt_q;
    if (clear) begin
      fp_cnt_d = '0;
      fn_cnt_d = '0;
    end else if (accept) begin
      if (pred && !label) fp_cnt_d = fp_cnt_q + ONE;
      if (!pred && label) fn_cnt_d = fn_cnt_q + ONE;
    end
  end

  // Confusion counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_cnt_q <= '0;
      fn_cnt_q <= '0;
    end else begin
      fp_cnt_q <= fp_cnt_d;
      fn_cnt_q <= fn_cnt_d;
    end
  end

  assign fp_cnt = fp_cnt_q;
  assign fn_cnt = fn_cnt_q;
`else
  assign fp_cnt = '0;
  assign fn_cnt = '0;
`endif

endmodule

// File: tb/tb_neuron_batch_scorer.sv
// tb_neuron_batch_scorer: directed stimulus for neuron_batch_scorer with a
// behavioural batch model checked every cycle plus literal expectations.
module tb_neuron_batch_scorer;

  localparam int BATCH_LEN = 4;
  localparam int CNT_W     = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             pred;
  logic             label;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] fp_cnt;
  logic [CNT_W-1:0] fn_cnt;

  int checks;
  int errors;

  neuron_batch_scorer #(
    .BATCH_LEN(BATCH_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pred       (pred),
    .label      (label),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .correct_cnt(correct_cnt),
    .ones_cnt   (ones_cnt),
    .fp_cnt     (fp_cnt),
    .fn_cnt     (fn_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a batch is "running" until BATCH_LEN samples have been
  // taken, followed by one "finished" cycle; totals are tallied directly.
  logic m_running;
  logic m_finished;
  int   m_samples;
  int   m_correct;
  int   m_ones;
  int   m_fp;
  int   m_fn;

  // Model update on each clock edge, reset asynchronously
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running  <= 1'b0;
      m_finished <= 1'b0;
      m_samples  <= 0;
      m_correct  <= 0;
      m_ones     <= 0;
      m_fp       <= 0;
      m_fn       <= 0;
    end else if (m_finished) begin
      m_finished <= 1'b0;
    end else if (m_running) begin
      if (in_valid) begin
        m_samples <= m_samples + 1;
        m_correct <= m_correct + ((pred == label) ? 1 : 0);
        m_ones    <= m_ones + (pred ? 1 : 0);
        m_fp      <= m_fp + ((pred && !label) ? 1 : 0);
        m_fn      <= m_fn + ((!pred && label) ? 1 : 0);
        if (m_samples + 1 == BATCH_LEN) begin
          m_running  <= 1'b0;
          m_finished <= 1'b1;
        end
      end
    end else if (start) begin
      m_running <= 1'b1;
      m_samples <= 0;
      m_correct <= 0;
      m_ones    <= 0;
      m_fp      <= 0;
      m_fn      <= 0;
    end
  end

  function automatic int confExp(input int v);
`ifdef SCORER_CONFUSION_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("m_in_ready", int'(in_ready), int'(m_running));
      checkOutput("m_busy", int'(busy), int'(m_running));
      checkOutput("m_done", int'(done), int'(m_finished));
      checkOutput("m_sample_cnt", int'(sample_cnt), m_samples);
      checkOutput("m_correct_cnt", int'(correct_cnt), m_correct);
      checkOutput("m_ones_cnt", int'(ones_cnt), m_ones);
      checkOutput("m_fp_cnt", int'(fp_cnt), confExp(m_fp));
      checkOutput("m_fn_cnt", int'(fn_cnt), confExp(m_fn));
`ifdef SCORER_CONFUSION_EN
      checkOutput("m_invariant", int'(correct_cnt) + int'(fp_cnt) + int'(fn_cnt), int'(sample_cnt));
`endif
    end
  end

  // Drive one cycle of inputs; called 2 ns after a rising edge, returns likewise
  task automatic applyStimulus(input logic s, input logic v, input logic p, input logic l);
    start    = s;
    in_valid = v;
    pred     = p;
    label    = l;
    @(posedge clk);
    #2;
  endtask

  task automatic checkCounts(input string name, input int s, input int c, input int o,
                             input int fp, input int fn);
    checkOutput({name, "_sample"}, int'(sample_cnt), s);
    checkOutput({name, "_correct"}, int'(correct_cnt), c);
    checkOutput({name, "_ones"}, int'(ones_cnt), o);
    checkOutput({name, "_fp"}, int'(fp_cnt), confExp(fp));
    checkOutput({name, "_fn"}, int'(fn_cnt), confExp(fn));
  endtask

  // Fixed sample set: (1,1) (0,1) (1,0) (0,0)
  logic [3:0] vec_pred;
  logic [3:0] vec_label;

  initial begin
    checks    = 0;
    errors    = 0;
    vec_pred  = 4'b0101;
    vec_label = 4'b0011;
    start     = 1'b0;
    in_valid  = 1'b0;
    pred      = 1'b0;
    label     = 1'b0;
    rst_n     = 1'b0;

    // Reset and idle with valid samples but no start
    repeat (3) @(posedge clk);
    #2;
    checkCounts("reset", 0, 0, 0, 0, 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("idle_ready", int'(in_ready), 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkCounts("idle", 0, 0, 0, 0, 0);
    end

    // Basic back-to-back batch
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_busy", int'(busy), 1);
    checkCounts("start", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("basic_done_early", int'(done), 0);
      applyStimulus(1'b0, 1'b1, vec_pred[i], vec_label[i]);
    end
    checkOutput("basic_done", int'(done), 1);
    checkCounts("basic", 4, 2, 2, 1, 1);

    // Hold after done with valid asserted, then restart
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("hold_done", int'(done), 0);
      checkCounts("hold", 4, 2, 2, 1, 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkCounts("restart", 0, 0, 0, 0, 0);
    checkOutput("restart_ready", int'(in_ready), 1);

    // Gapped batch: two idle cycles between samples
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, vec_pred[i], vec_label[i]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
          checkOutput("gap_busy", int'(busy), 1);
        end
      end
    end
    checkOutput("gap_done", int'(done), 1);
    checkCounts("gap", 4, 2, 2, 1, 1);

    // Start during the done cycle is ignored; the next one in IDLE is honoured
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_in_done_busy", int'(busy), 0);
    checkCounts("start_in_done", 4, 2, 2, 1, 1);

    // Ignored start mid-run
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ign_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkCounts("ign_mid", 2, 2, 2, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ign_done_early", int'(done), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ign_done", int'(done), 1);
    checkCounts("ign", 4, 3, 3, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkCounts("pre_rst", 2, 2, 2, 0, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkCounts("mid_rst", 0, 0, 0, 0, 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("post_rst_done", int'(done), 0);
      checkOutput("post_rst_busy", int'(busy), 0);
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
